xb_membank_bridge: RTL and testbench
====================================

Name: xb_membank_bridge

Overview:
- Parametrised successor to the three fixed 16-bit auxcmd membank write streams: NUM_BANKS independent host-addressable Xillybus write streams, each with a ping-pong (shadow/active) RAM bank.
- Sits between the Xillybus core's addressable write ports and the acquisition sequencer.
- Host fills the shadow copy; the swap to active happens only at a sequencer frame boundary, so a frame never reads a half-written command list.

Parameters:
- NUM_BANKS, 3: number of independent streams/banks.
- DATA_W, 16: stream word width.
- ADDR_W, 10: bank address width; DEPTH = 2**ADDR_W words per half.
- HOST_ADDR_W, 16: width of the Xillybus address bus.

Ports:
- bus_clk  in  1  single clock, Xillybus bus_clk domain.
- bus_rst_n  in  1  asynchronous active-low reset.
- wr_open  in  NUM_BANKS  per-stream open flag from Xillybus.
- wr_wren  in  NUM_BANKS  per-stream write strobe.
- wr_data  in  NUM_BANKS*DATA_W  per-stream write data.
- wr_full  out  NUM_BANKS  per-stream full to Xillybus.
- host_addr  in  NUM_BANKS*HOST_ADDR_W  per-stream seek address.
- host_addr_update  in  NUM_BANKS  per-stream address load strobe.
- seq_frame_end  in  1  single-cycle frame-boundary strobe; the only swap point.
- seq_rd_en  in  NUM_BANKS  sequencer read enable.
- seq_rd_addr  in  NUM_BANKS*ADDR_W  sequencer read address (active half).
- seq_rd_data  out  NUM_BANKS*DATA_W  read data.
- bank_pending  out  NUM_BANKS  shadow committed, awaiting swap.
- range_err  out  NUM_BANKS  sticky out-of-range write flag.

Behaviour:
- Reset values: all outputs 0; active select = half 0; write pointers 0; pending 0. Reset mid-operation aborts any commit with no swap; RAM contents are undefined, not cleared.

Per-bank write FSM, states IDLE, FILL, PENDING:
- IDLE -> FILL: on wr_open rising. Write pointer = 0, range_err cleared.
- FILL:
  - host_addr_update loads the pointer from host_addr[ADDR_W-1:0].
  - If host_addr[HOST_ADDR_W-1:ADDR_W] != 0, set an out-of-range latch.
  - Each wren writes wr_data to shadow[ptr], then ptr increments.
  - If wren and addr_update occur in the same cycle, the update wins and the data is written at the new address.
  - When ptr wraps from DEPTH-1 to 0, the next write is dropped and range_err is set. Further writes stay dropped until the next addr_update.
  - A write while the out-of-range latch is set is dropped and sets range_err.
- FILL -> PENDING: on wr_open falling (commit). bank_pending = 1 on the next cycle.
- PENDING:
  - wr_full = 1 and writes are ignored.
  - On seq_frame_end, the active select toggles, bank_pending -> 0 on the next cycle, and the state returns to IDLE.
  - If wr_open rises while PENDING, hold PENDING. Go directly to FILL after the swap.
- Simultaneous events:
  - Commit (open falling) in the same cycle as seq_frame_end: no swap. The swap waits for the next frame_end.
  - wr_full is 0 in IDLE and FILL.

Swap and read path:
- All banks swap independently, each on its own pending flag.
- seq_rd_data has 1-cycle latency from seq_rd_en, read from the active half.
- seq_rd_data holds its value when rd_en = 0.
- A swap takes effect for reads issued in the cycle after frame_end.

Optional Feature:
- Macro XB_MEMBANK_READBACK_EN.
- When defined, adds ports rd_open/rd_rden (NUM_BANKS), rd_data (NUM_BANKS*DATA_W), rd_empty/rd_eof (NUM_BANKS):
  - Host reads back the shadow half from the current pointer with auto-increment.
  - 1-cycle data latency.
  - rd_eof = 1 after word DEPTH-1.
  - rd_empty = 0 while open.
  - Readback is only allowed in IDLE/PENDING; in FILL, rd_empty = 1.
- When not defined, the ports are absent and each shadow RAM is simple dual-port (one write port, one read port).

Decomposition:
- Package xb_membank_pkg: write-FSM state enum (IDLE/FILL/PENDING), DEPTH derivation function, and a field-slice helper for flattened per-bank vectors.
- One sub-module, xb_membank_half_ram: 2×DEPTH×DATA_W RAM with a half-select bit, one write port (shadow) and one synchronous read port (active). Instantiated NUM_BANKS times in a generate loop with the per-bank FSM.

Test Plan:
- Basic commit/swap, bank 0: open, write 0x1111..0x1104 from addr 0, close, pulse frame_end -> bank_pending 1 then 0; seq reads addr 0..3 return 0x1111..0x1104 one cycle after rd_en.
- Seek and collision: addr_update = 5 together with wren data 0xABCD -> word lands at 5; next write lands at 6.
- Range errors:
  - host_addr = 0x0400 with ADDR_W = 10 -> writes dropped, range_err = 1.
  - DEPTH+1 sequential writes -> first DEPTH words stored, last dropped, range_err = 1.
- Frame gating:
  - Commit in the same cycle as frame_end -> no swap; next frame_end swaps.
  - While PENDING, wr_full = 1 and writes are ignored.
- Independence and reset:
  - Bank 1 committed, bank 2 filling, frame_end -> only bank 1 swaps.
  - bus_rst_n low mid-FILL -> all outputs 0, active half 0.
- XB_MEMBANK_READBACK_EN build: after commit, readback returns the written shadow words; rd_eof = 1 after word DEPTH-1.

Source files
------------

// File: rtl/xb_membank_pkg.sv
// -----------------------------------------------------------------------------
// xb_membank_pkg
// Shared types and helpers for the Xillybus command-membank bridge.
//   wr_state_t : per-bank host write FSM state (IDLE / FILL / PENDING)
//   depth_of   : words per RAM half for a given bank address width
//   field_lsb  : LSB of field idx inside a flattened per-bank vector
// Optional feature macro used by the bridge: XB_MEMBANK_READBACK_EN
// -----------------------------------------------------------------------------
package xb_membank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PENDING = 2'd2
  } wr_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/xb_membank_bridge_if.sv
// -----------------------------------------------------------------------------
// xb_membank_bridge_if
// Bundles the Xillybus write-stream ports, the host seek ports and the
// sequencer read ports of the membank bridge. All vectors are flattened
// per bank (bank i occupies field i).
// Modports:
//   slave  : the bridge (consumes host writes / sequencer reads)
//   master : the Xillybus core + sequencer side
// With XB_MEMBANK_READBACK_EN defined, the host readback stream
// (rd_open, rd_rden, rd_data, rd_empty, rd_eof) is added.
// -----------------------------------------------------------------------------
interface xb_membank_bridge_if #(
  parameter int NUM_BANKS   = 3,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int HOST_ADDR_W = 16
);

  logic [NUM_BANKS-1:0]             wr_open;
  logic [NUM_BANKS-1:0]             wr_wren;
  logic [NUM_BANKS*DATA_W-1:0]      wr_data;
  logic [NUM_BANKS-1:0]             wr_full;
  logic [NUM_BANKS*HOST_ADDR_W-1:0] host_addr;
  logic [NUM_BANKS-1:0]             host_addr_update;
  logic                             seq_frame_end;
  logic [NUM_BANKS-1:0]             seq_rd_en;
  logic [NUM_BANKS*ADDR_W-1:0]      seq_rd_addr;
  logic [NUM_BANKS*DATA_W-1:0]      seq_rd_data;
  logic [NUM_BANKS-1:0]             bank_pending;
  logic [NUM_BANKS-1:0]             range_err;
`ifdef XB_MEMBANK_READBACK_EN
  logic [NUM_BANKS-1:0]             rd_open;
  logic [NUM_BANKS-1:0]             rd_rden;
  logic [NUM_BANKS*DATA_W-1:0]      rd_data;
  logic [NUM_BANKS-1:0]             rd_empty;
  logic [NUM_BANKS-1:0]             rd_eof;
`endif

  modport slave (
`ifdef XB_MEMBANK_READBACK_EN
    input  rd_open, rd_rden,
    output rd_data, rd_empty, rd_eof,
`endif
    input  wr_open, wr_wren, wr_data, host_addr, host_addr_update,
    input  seq_frame_end, seq_rd_en, seq_rd_addr,
    output wr_full, seq_rd_data, bank_pending, range_err
  );

  modport master (
`ifdef XB_MEMBANK_READBACK_EN
    output rd_open, rd_rden,
    input  rd_data, rd_empty, rd_eof,
`endif
    output wr_open, wr_wren, wr_data, host_addr, host_addr_update,
    output seq_frame_end, seq_rd_en, seq_rd_addr,
    input  wr_full, seq_rd_data, bank_pending, range_err
  );

endinterface

// File: rtl/xb_membank_half_ram.sv
// -----------------------------------------------------------------------------
// xb_membank_half_ram
// Ping-pong command RAM: 2 x DEPTH x DATA_W words, the half picked by a
// select bit on each port. Contents are never reset.
// Ports:
//   clk                      : clock
//   we, wsel, waddr, wdata   : write port (shadow half)
//   re, rsel, raddr, rdata   : registered read port (active half); rdata holds
//                              while re is low
//   rb_re, rb_sel, rb_addr, rb_data : second registered read port, present
//                              only with XB_MEMBANK_READBACK_EN
// -----------------------------------------------------------------------------
module xb_membank_half_ram
  import xb_membank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wsel,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rsel,
  input  logic [ADDR_W-1:0] raddr,
`ifdef XB_MEMBANK_READBACK_EN
  input  logic              rb_re,
  input  logic              rb_sel,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wsel, waddr}] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[{rsel, raddr}];
    end
  end

  assign rdata = rdata_reg;

`ifdef XB_MEMBANK_READBACK_EN
  logic [DATA_W-1:0] rb_data_reg;

  always_ff @(posedge clk) begin
    if (rb_re) begin
      rb_data_reg <= mem[{rb_sel, rb_addr}];
    end
  end

  assign rb_data = rb_data_reg;
`endif

endmodule

// File: rtl/xb_membank_bridge.sv
// -----------------------------------------------------------------------------
// xb_membank_bridge
// NUM_BANKS independent host-addressable Xillybus write streams, each filling
// the shadow half of a ping-pong RAM. A closed (committed) shadow becomes the
// active half only on seq_frame_end, so the sequencer never sees a partially
// written command list.
// Ports:
//   bus_clk   : single clock (Xillybus bus_clk)
//   bus_rst_n : asynchronous active-low reset
//   bus       : xb_membank_bridge_if.slave (write streams, seek, sequencer
//               read port, pending/range_err status)
// Optional feature: XB_MEMBANK_READBACK_EN adds a host readback stream over
// the shadow half (allowed only outside FILL).
// -----------------------------------------------------------------------------
module xb_membank_bridge
  import xb_membank_pkg::*;
#(
  parameter int NUM_BANKS   = 3,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int HOST_ADDR_W = 16
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  xb_membank_bridge_if.slave bus
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam int DL = field_lsb(gi, DATA_W);
      localparam int AL = field_lsb(gi, ADDR_W);
      localparam int HL = field_lsb(gi, HOST_ADDR_W);

      wr_state_t         state_reg, state_next;
      logic [ADDR_W-1:0] ptr_reg, ptr_next;
      logic              wrap_reg, wrap_next;     // ptr wrapped: drop writes until a seek
      logic              oor_reg, oor_next;       // last seek was beyond the bank
      logic              err_reg, err_next;
      logic              active_reg, active_next; // half the sequencer reads
      logic              open_d_reg;
      logic              seq_valid_reg;           // masks the unreset RAM output

      logic [DATA_W-1:0]      wdata;
      logic [HOST_ADDR_W-1:0] haddr;
      logic                   haddr_oor;
      logic                   open_rise, open_fall;
      logic                   ram_we;
      logic [ADDR_W-1:0]      ram_waddr;
      logic [DATA_W-1:0]      ram_q;
      logic                   shadow_sel;
      logic                   start_fill;
      logic [ADDR_W-1:0]      eff_ptr;
      logic                   eff_oor, eff_wrap;

      assign wdata      = bus.wr_data[DL +: DATA_W];
      assign haddr      = bus.host_addr[HL +: HOST_ADDR_W];
      assign haddr_oor  = (haddr >> ADDR_W) != '0;
      assign open_rise  = bus.wr_open[gi] & ~open_d_reg;
      assign open_fall  = ~bus.wr_open[gi] & open_d_reg;
      assign shadow_sel = ~active_reg;

`ifdef XB_MEMBANK_READBACK_EN
      logic              eof_reg, eof_next;
      logic              rb_valid_reg;
      logic              rb_re;
      logic [DATA_W-1:0] rb_q;
`endif

      always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        wrap_next   = wrap_reg;
        oor_next    = oor_reg;
        err_next    = err_reg;
        active_next = active_reg;
        ram_we      = 1'b0;
        ram_waddr   = ptr_reg;
        start_fill  = 1'b0;
        eff_ptr     = ptr_reg;
        eff_oor     = oor_reg;
        eff_wrap    = wrap_reg;
`ifdef XB_MEMBANK_READBACK_EN
        eof_next    = eof_reg;
        rb_re       = 1'b0;
        // Outside FILL the pointer serves the readback stream: seek wins over
        // an auto-increment read in the same cycle.
        if (state_reg != ST_FILL) begin
          if (bus.host_addr_update[gi]) begin
            ptr_next = haddr[ADDR_W-1:0];
            eof_next = 1'b0;
          end else if (bus.rd_open[gi] && bus.rd_rden[gi]) begin
            rb_re    = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            if (ptr_reg == '1) begin
              eof_next = 1'b1;
            end
          end
        end
`endif

        case (state_reg)
          ST_IDLE: begin
            if (open_rise) begin
              state_next = ST_FILL;
              start_fill = 1'b1;
            end
          end

          ST_FILL: begin
            // A seek in the same cycle as a write redirects that write.
            if (bus.host_addr_update[gi]) begin
              eff_ptr  = haddr[ADDR_W-1:0];
              eff_oor  = haddr_oor;
              eff_wrap = 1'b0;
            end
            ptr_next  = eff_ptr;
            oor_next  = eff_oor;
            wrap_next = eff_wrap;
            if (bus.wr_wren[gi]) begin
              if (eff_oor || eff_wrap) begin
                err_next = 1'b1;
              end else begin
                ram_we    = 1'b1;
                ram_waddr = eff_ptr;
                ptr_next  = eff_ptr + 1'b1;
                if (eff_ptr == '1) begin
                  wrap_next = 1'b1;
                end
              end
            end
            // A frame_end coinciding with the commit is deliberately ignored:
            // the swap waits for the next frame boundary.
            if (open_fall) begin
              state_next = ST_PENDING;
            end
          end

          ST_PENDING: begin
            if (bus.seq_frame_end) begin
              active_next = ~active_reg;
              // Host reopened while we waited: start the next fill right away.
              if (bus.wr_open[gi]) begin
                state_next = ST_FILL;
                start_fill = 1'b1;
              end else begin
                state_next = ST_IDLE;
              end
            end
          end

          default: begin
            state_next = ST_IDLE;
          end
        endcase

        if (start_fill) begin
          ptr_next  = '0;
          wrap_next = 1'b0;
          oor_next  = 1'b0;
          err_next  = 1'b0;
`ifdef XB_MEMBANK_READBACK_EN
          eof_next  = 1'b0;
`endif
        end
      end

      always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
          state_reg     <= ST_IDLE;
          ptr_reg       <= '0;
          wrap_reg      <= 1'b0;
          oor_reg       <= 1'b0;
          err_reg       <= 1'b0;
          active_reg    <= 1'b0;
          open_d_reg    <= 1'b0;
          seq_valid_reg <= 1'b0;
        end else begin
          state_reg     <= state_next;
          ptr_reg       <= ptr_next;
          wrap_reg      <= wrap_next;
          oor_reg       <= oor_next;
          err_reg       <= err_next;
          active_reg    <= active_next;
          open_d_reg    <= bus.wr_open[gi];
          if (bus.seq_rd_en[gi]) begin
            seq_valid_reg <= 1'b1;
          end
        end
      end

      xb_membank_half_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_ram (
        .clk     (bus_clk),
        .we      (ram_we),
        .wsel    (shadow_sel),
        .waddr   (ram_waddr),
        .wdata   (wdata),
        .re      (bus.seq_rd_en[gi]),
        .rsel    (active_reg),
        .raddr   (bus.seq_rd_addr[AL +: ADDR_W]),
`ifdef XB_MEMBANK_READBACK_EN
        .rb_re   (rb_re),
        .rb_sel  (shadow_sel),
        .rb_addr (ptr_reg),
        .rb_data (rb_q),
`endif
        .rdata   (ram_q)
      );

      assign bus.wr_full[gi]              = (state_reg == ST_PENDING);
      assign bus.bank_pending[gi]         = (state_reg == ST_PENDING);
      assign bus.range_err[gi]            = err_reg;
      assign bus.seq_rd_data[DL +: DATA_W] = seq_valid_reg ? ram_q : '0;

`ifdef XB_MEMBANK_READBACK_EN
      always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
          eof_reg      <= 1'b0;
          rb_valid_reg <= 1'b0;
        end else begin
          eof_reg <= eof_next;
          if (rb_re) begin
            rb_valid_reg <= 1'b1;
          end
        end
      end

      assign bus.rd_data[DL +: DATA_W] = rb_valid_reg ? rb_q : '0;
      assign bus.rd_empty[gi]          = (state_reg == ST_FILL);
      assign bus.rd_eof[gi]            = eof_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_xb_membank_bridge.sv
// -----------------------------------------------------------------------------
// tb_xb_membank_bridge
// Directed test of xb_membank_bridge with default parameters
// (3 banks, 16-bit data, 10-bit bank address, 16-bit host address).
// -----------------------------------------------------------------------------
module tb_xb_membank_bridge;

  localparam int NB    = 3;
  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int HW    = 16;
  localparam int DEPTH = 1 << AW;

  logic bus_clk;
  logic bus_rst_n;

  int total = 0;
  int bad   = 0;

  xb_membank_bridge_if #(
    .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .HOST_ADDR_W(HW)
  ) bus ();

  xb_membank_bridge #(
    .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .HOST_ADDR_W(HW)
  ) dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .bus       (bus)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wr(input int b, input logic [15:0] d);
    bus.wr_wren[b] = 1'b1;
    bus.wr_data[b*DW +: DW] = d;
    tick();
    bus.wr_wren[b] = 1'b0;
  endtask

  task automatic seek(input int b, input logic [15:0] a);
    bus.host_addr[b*HW +: HW] = a;
    bus.host_addr_update[b] = 1'b1;
    tick();
    bus.host_addr_update[b] = 1'b0;
  endtask

  task automatic set_open(input int b, input logic v);
    bus.wr_open[b] = v;
    tick();
  endtask

  task automatic frame();
    bus.seq_frame_end = 1'b1;
    tick();
    bus.seq_frame_end = 1'b0;
  endtask

  task automatic seq_rd(input int b, input int a, output logic [15:0] q);
    logic [AW-1:0] a_w;
    a_w = a[AW-1:0];
    bus.seq_rd_en[b] = 1'b1;
    bus.seq_rd_addr[b*AW +: AW] = a_w;
    tick();
    bus.seq_rd_en[b] = 1'b0;
    q = bus.seq_rd_data[b*DW +: DW];
  endtask

`ifdef XB_MEMBANK_READBACK_EN
  task automatic rb_rd(input int b, output logic [15:0] q);
    bus.rd_rden[b] = 1'b1;
    tick();
    bus.rd_rden[b] = 1'b0;
    q = bus.rd_data[b*DW +: DW];
  endtask
`endif

  logic [15:0] q;
  logic [15:0] held;
  logic [15:0] exp_basic [4];

  initial begin
    exp_basic[0] = 16'h1111;
    exp_basic[1] = 16'h1102;
    exp_basic[2] = 16'h1103;
    exp_basic[3] = 16'h1104;

    bus_rst_n             = 1'b0;
    bus.wr_open           = '0;
    bus.wr_wren           = '0;
    bus.wr_data           = '0;
    bus.host_addr         = '0;
    bus.host_addr_update  = '0;
    bus.seq_frame_end     = 1'b0;
    bus.seq_rd_en         = '0;
    bus.seq_rd_addr       = '0;
`ifdef XB_MEMBANK_READBACK_EN
    bus.rd_open           = '0;
    bus.rd_rden           = '0;
`endif

    // ---- reset state
    tick();
    tick();
    check("rst_wr_full", 32'(bus.wr_full), 32'h0);
    check("rst_pending", 32'(bus.bank_pending), 32'h0);
    check("rst_range_err", 32'(bus.range_err), 32'h0);
    check("rst_seq_rd_data", 32'(bus.seq_rd_data), 32'h0);
    bus_rst_n = 1'b1;
    tick();

    // ---- basic commit / swap, bank 0 (fills half 1, then half 1 active)
    set_open(0, 1'b1);
    for (int i = 0; i < 4; i++) wr(0, exp_basic[i]);
    check("basic_full_in_fill", 32'(bus.wr_full[0]), 32'h0);
    set_open(0, 1'b0);
    check("basic_pending_set", 32'(bus.bank_pending[0]), 32'h1);
    check("basic_full_pending", 32'(bus.wr_full[0]), 32'h1);
    frame();
    check("basic_pending_clr", 32'(bus.bank_pending[0]), 32'h0);
    check("basic_full_clr", 32'(bus.wr_full[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      seq_rd(0, i, q);
      check($sformatf("basic_rd%0d", i), 32'(q), 32'(exp_basic[i]));
    end
    held = q;
    tick();
    check("basic_rd_hold", 32'(bus.seq_rd_data[0 +: DW]), 32'(held));

    // ---- seek + write collision, bank 0 (fills half 0)
    set_open(0, 1'b1);
    bus.host_addr[0 +: HW] = 16'd5;
    bus.host_addr_update[0] = 1'b1;
    wr(0, 16'hABCD);
    bus.host_addr_update[0] = 1'b0;
    wr(0, 16'h5555);
    set_open(0, 1'b0);
    frame();
    seq_rd(0, 5, q);
    check("seek_collide_addr5", 32'(q), 32'hABCD);
    seq_rd(0, 6, q);
    check("seek_next_addr6", 32'(q), 32'h5555);

    // ---- out-of-range seek, bank 0 (shadow half 1 still holds 0x1111 at 0)
    set_open(0, 1'b1);
    check("oor_err_clear_on_open", 32'(bus.range_err[0]), 32'h0);
    seek(0, 16'h0400);
    check("oor_seek_alone_no_err", 32'(bus.range_err[0]), 32'h0);
    wr(0, 16'h7777);
    check("oor_err_set", 32'(bus.range_err[0]), 32'h1);
    set_open(0, 1'b0);
    frame();
    check("oor_err_sticky", 32'(bus.range_err[0]), 32'h1);
    seq_rd(0, 0, q);
    check("oor_write_dropped", 32'(q), 32'h1111);

    // ---- pointer wrap, bank 1 (fills half 1)
    set_open(1, 1'b1);
    for (int i = 0; i < DEPTH; i++) wr(1, 16'(16'h2000 + i));
    check("wrap_no_err_at_depth", 32'(bus.range_err[1]), 32'h0);
    wr(1, 16'h2400);
    check("wrap_err_set", 32'(bus.range_err[1]), 32'h1);
    wr(1, 16'h2401);
    seek(1, 16'd2);
    wr(1, 16'h3333);
    set_open(1, 1'b0);
    frame();
    seq_rd(1, 0, q);
    check("wrap_addr0_kept", 32'(q), 32'h2000);
    seq_rd(1, DEPTH - 1, q);
    check("wrap_last_word", 32'(q), 32'h23FF);
    seq_rd(1, 2, q);
    check("wrap_reseek_write", 32'(q), 32'h3333);

    // ---- frame gating, bank 2: commit coincides with frame_end
    set_open(2, 1'b1);
    wr(2, 16'hC001);
    seek(2, 16'd0);
    bus.wr_open[2] = 1'b0;
    bus.seq_frame_end = 1'b1;
    tick();
    bus.seq_frame_end = 1'b0;
    check("gate_no_swap_pending", 32'(bus.bank_pending[2]), 32'h1);
    check("gate_full", 32'(bus.wr_full[2]), 32'h1);
    wr(2, 16'hDEAD);
    check("gate_still_pending", 32'(bus.bank_pending[2]), 32'h1);
    frame();
    check("gate_swapped", 32'(bus.bank_pending[2]), 32'h0);
    seq_rd(2, 0, q);
    check("gate_pending_write_ignored", 32'(q), 32'hC001);

    // ---- independence: bank 1 committed, bank 2 filling
    set_open(1, 1'b1);
    wr(1, 16'h4441);
    set_open(1, 1'b0);
    set_open(2, 1'b1);
    wr(2, 16'h5551);
    frame();
    check("indep_b1_swapped", 32'(bus.bank_pending[1]), 32'h0);
    check("indep_b2_not_full", 32'(bus.wr_full[2]), 32'h0);
    seq_rd(1, 0, q);
    check("indep_b1_new_data", 32'(q), 32'h4441);
    seq_rd(2, 0, q);
    check("indep_b2_old_data", 32'(q), 32'hC001);
    set_open(2, 1'b0);
    check("indep_b2_pending", 32'(bus.bank_pending[2]), 32'h1);
    frame();
    seq_rd(2, 0, q);
    check("indep_b2_swapped", 32'(q), 32'h5551);

`ifdef XB_MEMBANK_READBACK_EN
    // ---- readback of bank 1 shadow (half 1: wrap data, 0x3333 at 2)
    seek(1, 16'd0);
    bus.rd_open[1] = 1'b1;
    tick();
    check("rb_not_empty", 32'(bus.rd_empty[1]), 32'h0);
    rb_rd(1, q);
    check("rb_word0", 32'(q), 32'h2000);
    rb_rd(1, q);
    check("rb_word1", 32'(q), 32'h2001);
    seek(1, 16'(DEPTH - 2));
    rb_rd(1, q);
    check("rb_word_depth_m2", 32'(q), 32'h23FE);
    check("rb_eof_before_last", 32'(bus.rd_eof[1]), 32'h0);
    rb_rd(1, q);
    check("rb_word_last", 32'(q), 32'h23FF);
    check("rb_eof_after_last", 32'(bus.rd_eof[1]), 32'h1);
    bus.rd_open[1] = 1'b0;
    tick();
`endif

    // ---- reset mid-FILL, bank 0 (active half 1, filling half 0)
    set_open(0, 1'b1);
    wr(0, 16'h9999);
    seek(0, 16'h0800);
    wr(0, 16'h8888);
    check("rstmid_err_before", 32'(bus.range_err[0]), 32'h1);
    bus_rst_n = 1'b0;
    #1;
    check("rstmid_wr_full", 32'(bus.wr_full), 32'h0);
    check("rstmid_pending", 32'(bus.bank_pending), 32'h0);
    check("rstmid_range_err", 32'(bus.range_err), 32'h0);
    check("rstmid_seq_rd_data", 32'(bus.seq_rd_data), 32'h0);
    bus.wr_open = '0;
    tick();
    bus_rst_n = 1'b1;
    tick();
    // Half 0 of bank 0 still holds 0xABCD at 5 in the simulation model,
    // so reading it shows the active select went back to half 0.
    seq_rd(0, 5, q);
    check("rstmid_active_half0", 32'(q), 32'hABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
